// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the front end: data width, default reset PC,
// major opcodes, the fetch-packet record carried through the instruction
// queue, and the J-type immediate extractor used by fetch-side predecode.
// ----------------------------------------------------------------------------
package riscv_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  // Takes instr[31:12]; returns the sign-extended, byte-granular J offset.
  function automatic logic signed [XLEN-1:0] j_imm(input logic [19:0] hi);
    logic signed [XLEN-1:0] imm;
    imm = {{12{hi[19]}}, hi[7:0], hi[8], hi[18:9], 1'b0};
    return imm;
  endfunction

  // True for any opcode that can change control flow.
  function automatic logic is_cflow(input logic [6:0] op);
    return (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/if_queue.sv
// ----------------------------------------------------------------------------
// if_queue
// In-order synchronous FIFO of fetch packets between fetch and decode.
//   clk, rst_n   : clock, synchronous active-low reset (pointers/count only)
//   push/push_data : enqueue a packet
//   pop          : dequeue the head (ignored when empty)
//   flush        : discard all entries; wins over push/pop
//   head         : packet at the head (meaningful only when !empty)
//   count/full/empty : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module if_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_pkt_t                 push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_pkt_t                 head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_pkt_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  cnt;
  logic           do_push;
  logic           do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  // A full queue may still accept when its head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction fetch: owns the PC, issues word fetches, buffers responses in
// an in-order queue and presents {instr, pc, pc+4} to decode.
//   clk, rst_n        : clock, synchronous active-low reset
//   imem_req_*        : fetch request (valid/ready handshake, word address)
//   imem_rsp_*        : in-order fetch response, latency >= 1
//   redirect_valid/pc : control-flow change from EX; flushes the front end
//   id_stall          : decode holds the current head
//   id_valid/instr/pc/pc4 : queue head towards decode (zero when empty)
// Optional build macro IF_JAL_PREDICT_EN: predecode live responses and
// follow JAL targets at fetch, killing the sequential fetches behind them.
// ----------------------------------------------------------------------------
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   fetch_pc,  fetch_pc_nxt;
  logic [CW-1:0] out_cnt,   out_cnt_nxt;
  logic [CW-1:0] kill_cnt,  kill_cnt_nxt;

  // PCs of outstanding requests, oldest first; popped by every response.
  logic [31:0]   pcq [DEPTH];
  logic [AW-1:0] pcq_wr;
  logic [AW-1:0] pcq_rd;

  logic          acc;
  logic          rsp_live;
  logic [31:0]   rsp_pc;
  logic [31:0]   redir_target;
  logic [CW:0]   credit_sum;

  fetch_pkt_t    q_head;
  fetch_pkt_t    q_push_data;
  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;
  logic          q_pop;

`ifdef IF_JAL_PREDICT_EN
  logic          jal_hit;
  logic [31:0]   jal_target;
`endif

  assign credit_sum     = {1'b0, out_cnt} + {1'b0, q_count};
  assign imem_req_valid = rst_n & ~redirect_valid & (credit_sum < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign acc            = imem_req_valid & imem_req_ready;

  assign redir_target   = redirect_pc & ~32'h3;
  assign rsp_pc         = pcq[pcq_rd];
  // A response is live only when it is not owed to a killed request and
  // no redirect is discarding the whole front end this cycle.
  assign rsp_live       = imem_rsp_valid & ~redirect_valid & (kill_cnt == '0);
  assign q_push_data    = '{instr: imem_rsp_data, pc: rsp_pc};
  assign q_pop          = ~q_empty & ~id_stall & ~redirect_valid;

`ifdef IF_JAL_PREDICT_EN
  assign jal_hit    = rsp_live & (imem_rsp_data[6:0] == OP_JAL);
  assign jal_target = rsp_pc + $unsigned(j_imm(imem_rsp_data[31:12]));
`endif

  always_comb begin
    fetch_pc_nxt = fetch_pc;
    out_cnt_nxt  = out_cnt;
    kill_cnt_nxt = kill_cnt;

    case ({acc, imem_rsp_valid})
      2'b10:   out_cnt_nxt = out_cnt + CW'(1);
      2'b01:   out_cnt_nxt = out_cnt - CW'(1);
      default: out_cnt_nxt = out_cnt;
    endcase

    if (acc) fetch_pc_nxt = fetch_pc + 32'd4;
    if (imem_rsp_valid && (kill_cnt != '0)) kill_cnt_nxt = kill_cnt - CW'(1);

`ifdef IF_JAL_PREDICT_EN
    // Everything still in flight behind the JAL is sequential and stale,
    // including a request accepted in this same cycle.
    if (jal_hit) begin
      fetch_pc_nxt = jal_target;
      kill_cnt_nxt = out_cnt - CW'(1) + CW'(acc);
    end
`endif

    if (redirect_valid) begin
      fetch_pc_nxt = redir_target;
      kill_cnt_nxt = out_cnt - CW'(imem_rsp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      out_cnt  <= '0;
      kill_cnt <= '0;
      pcq_wr   <= '0;
      pcq_rd   <= '0;
    end else begin
      fetch_pc <= fetch_pc_nxt;
      out_cnt  <= out_cnt_nxt;
      kill_cnt <= kill_cnt_nxt;
      if (acc)            pcq_wr <= pcq_wr + AW'(1);
      if (imem_rsp_valid) pcq_rd <= pcq_rd + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (acc) pcq[pcq_wr] <= fetch_pc;
  end

  if_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_live),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign id_valid = ~q_empty;
  assign id_instr = q_empty ? 32'd0 : q_head.instr;
  assign id_pc    = q_empty ? 32'd0 : q_head.pc;
  assign id_pc4   = q_empty ? 32'd0 : q_head.pc + 32'd4;

  rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (out_cnt != '0));

  live_rsp_has_room: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_live |-> !q_full);

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;

  if_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc4         (id_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] JAL_P40 = 32'h0400_006F;

  int checks = 0;
  int fails  = 0;

  // Instruction memory model: in-order responses after 'lat' cycles.
  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;
  pend_t pq[$];
  int    cyc = 0;
  int    lat = 1;
  bit    jal_mode = 1'b0;

  function automatic logic [31:0] memw(input logic [31:0] a, input bit jm);
    if (jm && (a == 32'h0000_0010)) return JAL_P40;
    return a >> 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    pend_t p;
    #1;
    if (imem_req_valid && imem_req_ready) begin
      p.due  = cyc + lat;
      p.data = memw(imem_req_addr, jal_mode);
      pq.push_back(p);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) pq.delete();
    if (pq.size() > 0 && pq[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pq[0].data;
      void'(pq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    id_stall       = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_idv;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                              input logic rv, input logic [31:0] ad,
                              input logic iv, input logic [31:0] pc, input logic [31:0] ins);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rp;
    v.exp_rv = rv; v.exp_addr = ad;
    v.exp_idv = iv; v.exp_pc = pc; v.exp_instr = ins;
    return v;
  endfunction

  vec_t vt [22];

  initial begin
    logic [31:0] got_pc [6];
    logic [31:0] got_in [6];
    logic [31:0] exp_pc [6];
    int          n;
    bit          seen;

    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;

    // Latency-1 stream, stall for 5 cycles, then a redirect coinciding with
    // a response, landing at 0xFFFF_FFFC to exercise PC wrap.
    vt[0]  = mk(1'b0, 1'b0, 32'd0, 1'b1, 32'd0,  1'b0, 32'd0,  32'd0);
    vt[1]  = mk(1'b0, 1'b0, 32'd0, 1'b1, 32'd4,  1'b0, 32'd0,  32'd0);
    vt[2]  = mk(1'b0, 1'b0, 32'd0, 1'b0, 32'd0,  1'b1, 32'd0,  32'd0);
    vt[3]  = mk(1'b0, 1'b0, 32'd0, 1'b1, 32'd8,  1'b1, 32'd4,  32'd1);
    vt[4]  = mk(1'b0, 1'b0, 32'd0, 1'b1, 32'd12, 1'b0, 32'd0,  32'd0);
    vt[5]  = mk(1'b0, 1'b0, 32'd0, 1'b0, 32'd0,  1'b1, 32'd8,  32'd2);
    vt[6]  = mk(1'b1, 1'b0, 32'd0, 1'b1, 32'd16, 1'b1, 32'd12, 32'd3);
    vt[7]  = mk(1'b1, 1'b0, 32'd0, 1'b0, 32'd0,  1'b1, 32'd12, 32'd3);
    vt[8]  = mk(1'b1, 1'b0, 32'd0, 1'b0, 32'd0,  1'b1, 32'd12, 32'd3);
    vt[9]  = mk(1'b1, 1'b0, 32'd0, 1'b0, 32'd0,  1'b1, 32'd12, 32'd3);
    vt[10] = mk(1'b1, 1'b0, 32'd0, 1'b0, 32'd0,  1'b1, 32'd12, 32'd3);
    vt[11] = mk(1'b0, 1'b0, 32'd0, 1'b0, 32'd0,  1'b1, 32'd12, 32'd3);
    vt[12] = mk(1'b0, 1'b0, 32'd0, 1'b1, 32'd20, 1'b1, 32'd16, 32'd4);
    vt[13] = mk(1'b0, 1'b0, 32'd0, 1'b1, 32'd24, 1'b0, 32'd0,  32'd0);
    vt[14] = mk(1'b0, 1'b0, 32'd0, 1'b0, 32'd0,  1'b1, 32'd20, 32'd5);
    vt[15] = mk(1'b0, 1'b0, 32'd0, 1'b1, 32'd28, 1'b1, 32'd24, 32'd6);
    vt[16] = mk(1'b0, 1'b0, 32'd0, 1'b1, 32'd32, 1'b0, 32'd0,  32'd0);
    vt[17] = mk(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1, 32'd28, 32'd7);
    vt[18] = mk(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 32'd0);
    vt[19] = mk(1'b0, 1'b0, 32'd0, 1'b1, 32'd0,  1'b0, 32'd0,  32'd0);
    vt[20] = mk(1'b0, 1'b0, 32'd0, 1'b0, 32'd0,  1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFF);
    vt[21] = mk(1'b0, 1'b0, 32'd0, 1'b1, 32'd4,  1'b1, 32'd0,  32'd0);

    lat = 1;
    do_reset();
    // Still inside the reset window: bring reset back low briefly to sample.
    rst_n = 1'b0;
    #1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_id_valid",  {31'd0, id_valid}, 32'd0);
    chk("rst_id_instr",  id_instr, 32'd0);
    chk("rst_id_pc",     id_pc,    32'd0);
    chk("rst_id_pc4",    id_pc4,   32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      id_stall       = vt[i].stall;
      redirect_valid = vt[i].redir;
      redirect_pc    = vt[i].rpc;
      #1;
      chk($sformatf("v%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, vt[i].exp_rv});
      if (vt[i].exp_rv) chk($sformatf("v%0d_req_addr", i), imem_req_addr, vt[i].exp_addr);
      chk($sformatf("v%0d_id_valid", i), {31'd0, id_valid}, {31'd0, vt[i].exp_idv});
      if (vt[i].exp_idv) begin
        chk($sformatf("v%0d_id_pc", i),    id_pc,    vt[i].exp_pc);
        chk($sformatf("v%0d_id_instr", i), id_instr, vt[i].exp_instr);
        chk($sformatf("v%0d_id_pc4", i),   id_pc4,   vt[i].exp_pc + 32'd4);
      end
      tick();
    end
    redirect_valid = 1'b0;
    id_stall       = 1'b0;

    // Redirect while two requests are outstanding (imem latency 3).
    lat = 3;
    do_reset();
    #1;
    chk("r2_req0_addr", imem_req_addr, 32'd0);
    tick();
    #1;
    chk("r2_req1_valid", {31'd0, imem_req_valid}, 32'd1);
    redirect_valid = 1'b1;
    #1;
    chk("r2_redir_blocks_req", {31'd0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    chk("r2_redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("r2_idv_after_redir", {31'd0, id_valid}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      #1;
      if (id_valid) begin
        seen = 1'b1;
        chk("r2_first_pc",    id_pc,    32'h0000_0100);
        chk("r2_first_instr", id_instr, 32'h0000_0040);
        chk("r2_first_pc4",   id_pc4,   32'h0000_0104);
      end
      tick();
    end
    chk("r2_first_seen", {31'd0, seen}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      #1;
      if (id_valid) begin
        seen = 1'b1;
        chk("r2_second_pc", id_pc, 32'h0000_0104);
      end
      tick();
    end
    chk("r2_second_seen", {31'd0, seen}, 32'd1);

    // Reset mid-operation, together with stall and redirect.
    id_stall       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    rst_n          = 1'b0;
    tick();
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    rst_n          = 1'b1;
    #1;
    chk("mid_rst_id_valid",  {31'd0, id_valid}, 32'd0);
    chk("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("mid_rst_req_addr",  imem_req_addr, 32'd0);

    // JAL at 0x10 with offset +0x40.
    lat = 1;
    do_reset();
    jal_mode = 1'b1;
    exp_pc[0] = 32'h00; exp_pc[1] = 32'h04; exp_pc[2] = 32'h08;
    exp_pc[3] = 32'h0C; exp_pc[4] = 32'h10;
`ifdef IF_JAL_PREDICT_EN
    exp_pc[5] = 32'h50;
`else
    exp_pc[5] = 32'h14;
`endif
    n = 0;
    for (int k = 0; k < 60 && n < 6; k++) begin
      #1;
      if (id_valid) begin
        got_pc[n] = id_pc;
        got_in[n] = id_instr;
        n++;
      end
      tick();
    end
    chk("jal_count", n, 6);
    for (int j = 0; j < n; j++) begin
      chk($sformatf("jal_pc%0d", j), got_pc[j], exp_pc[j]);
      chk($sformatf("jal_instr%0d", j), got_in[j], (j == 4) ? JAL_P40 : (exp_pc[j] >> 2));
    end
    jal_mode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
